// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the MIPS32 pipeline hazard controller:
//   - ctrl_state_e    : controller state encoding (RUN / MEM_WAIT)
//   - REG_ZERO        : architectural r0, which never carries a dependency
//   - MDU_LATENCY_DEF : default mult/div occupancy in cycles
//   - STG_*           : index of each sequenced register (PC and stage regs)
//   - src_hits_dst()  : operand-vs-destination match used by load-use checks
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MDU_LATENCY_DEF = 32;

    // Index of each register the controller sequences. PC has a write
    // enable but no clear, so clear vectors start at STG_IFID.
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    function automatic logic src_hits_dst(input logic       uses,
                                          input logic [4:0] src,
                                          input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Hazard inputs (i_*)  : ID operand info, EX load/branch/MDU info, MEM
//                          request/ready handshake.
//   Control outputs (o_*): per-register write enables / synchronous clears,
//                          MDU busy flag, stall-cycle counter, state debug.
// Memory handshake: an access is in flight while i_mem_req is high; it
// completes on the cycle where i_mem_ready is also high. i_mem_req with
// i_mem_ready low is a wait state.
// Modports: master = datapath side, slave = controller side.
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic [4:0]       i_id_rs;
    logic [4:0]       i_id_rt;
    logic             i_id_uses_rs;
    logic             i_id_uses_rt;
    logic             i_id_jump;
    logic             i_id_mdu_read;
    logic             i_id_mdu_op;
    logic             i_ex_mem_read;
    logic [4:0]       i_ex_rd;
    logic             i_ex_branch_taken;
    logic             i_ex_mdu_start;
    logic             i_mem_req;
    logic             i_mem_ready;

    logic             o_pc_we;
    logic             o_ifid_we;
    logic             o_ifid_srst;
    logic             o_idex_we;
    logic             o_idex_srst;
    logic             o_exmem_we;
    logic             o_exmem_srst;
    logic             o_memwb_we;
    logic             o_memwb_srst;
    logic             o_mdu_busy;
    logic [CNT_W-1:0] o_stall_cycles;
    ctrl_state_e      o_state;

    modport master (
        output i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_id_jump,
               i_id_mdu_read, i_id_mdu_op, i_ex_mem_read, i_ex_rd,
               i_ex_branch_taken, i_ex_mdu_start, i_mem_req, i_mem_ready,
        input  o_pc_we, o_ifid_we, o_ifid_srst, o_idex_we, o_idex_srst,
               o_exmem_we, o_exmem_srst, o_memwb_we, o_memwb_srst,
               o_mdu_busy, o_stall_cycles, o_state
    );

    modport slave (
        input  i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_id_jump,
               i_id_mdu_read, i_id_mdu_op, i_ex_mem_read, i_ex_rd,
               i_ex_branch_taken, i_ex_mdu_start, i_mem_req, i_mem_ready,
        output o_pc_we, o_ifid_we, o_ifid_srst, o_idex_we, o_idex_srst,
               o_exmem_we, o_exmem_srst, o_memwb_we, o_memwb_srst,
               o_mdu_busy, o_stall_cycles, o_state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_busy_counter.sv
// ----------------------------------------------------------------------------
// mdu_busy_counter
// Tracks how long the multi-cycle mult/div unit stays occupied.
//   i_clk, i_a_rst_n : clock, asynchronous active-low reset
//   i_load           : a mult/div start is accepted this cycle
//   o_busy           : registered, high while the occupancy count is non-zero
// A load always wins over the decrement, so a start arriving on the last
// busy cycle restarts the full latency window.
// ----------------------------------------------------------------------------
module mdu_busy_counter #(
    parameter int MDU_LATENCY = 32
) (
    input  logic i_clk,
    input  logic i_a_rst_n,
    input  logic i_load,
    output logic o_busy
);

    localparam int CW = $clog2(MDU_LATENCY + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MDU_LATENCY);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencer for the 5-stage MIPS32 pipeline registers and the PC.
//   i_clk, i_a_rst_n : clock, asynchronous active-low reset
//   bus (slave)      : hazard inputs in, per-register write enable / clear,
//                      MDU busy, saturating stall-cycle counter, state out
// One action per cycle, highest priority first: memory wait, taken branch,
// ID stall (load-use or MDU structural/read), jump, normal advance.
// Control outputs are combinational; the state flag and counters are
// registered.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF,
    parameter int CNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_a_rst_n,
    pipe_hazard_ctrl_if.slave  bus
);

    ctrl_state_e                  state_q;
    logic [CNT_W-1:0]             stall_cnt_q;
    logic                         mdu_busy;
    logic                         mem_wait;
    logic                         load_use;
    logic                         mdu_hazard;
    logic                         id_stall;
    logic [STG_MEMWB:STG_PC]      we;
    logic [STG_MEMWB:STG_IFID]    srst;

    assign mem_wait = bus.i_mem_req && !bus.i_mem_ready;

    // r0 is hard-wired to zero, so a load targeting it creates no dependency.
    assign load_use = bus.i_ex_mem_read && (bus.i_ex_rd != REG_ZERO) &&
                      (src_hits_dst(bus.i_id_uses_rs, bus.i_id_rs, bus.i_ex_rd) ||
                       src_hits_dst(bus.i_id_uses_rt, bus.i_id_rt, bus.i_ex_rd));

    assign mdu_hazard = mdu_busy && (bus.i_id_mdu_read || bus.i_id_mdu_op);
    assign id_stall   = load_use || mdu_hazard;

    always_comb begin
        we   = '1;
        srst = '0;
        if (mem_wait) begin
            // Freeze everything upstream of WB; WB takes a bubble so the
            // stalled MEM instruction does not retire twice. A pending branch
            // is left to act once the access completes.
            we[STG_PC]      = 1'b0;
            we[STG_IFID]    = 1'b0;
            we[STG_IDEX]    = 1'b0;
            we[STG_EXMEM]   = 1'b0;
            srst[STG_MEMWB] = 1'b1;
        end else if (bus.i_ex_branch_taken) begin
            // ID and IF hold wrong-path instructions, so any ID stall is moot.
            srst[STG_IFID]  = 1'b1;
            srst[STG_IDEX]  = 1'b1;
        end else if (id_stall) begin
            we[STG_PC]      = 1'b0;
            we[STG_IFID]    = 1'b0;
            srst[STG_IDEX]  = 1'b1;
        end else if (bus.i_id_jump) begin
            // A jump seen during a stall is held in ID and handled here once
            // the stall drops.
            srst[STG_IFID]  = 1'b1;
        end
    end

    mdu_busy_counter #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_busy_counter (
        .i_clk     (i_clk),
        .i_a_rst_n (i_a_rst_n),
        .i_load    (bus.i_ex_mdu_start && we[STG_EXMEM]),
        .o_busy    (mdu_busy)
    );

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:      if (mem_wait)  state_q <= ST_MEM_WAIT;
                ST_MEM_WAIT: if (!mem_wait) state_q <= ST_RUN;
                default:                    state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            stall_cnt_q <= '0;
        end else if (!we[STG_PC] && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.o_pc_we        = we[STG_PC];
    assign bus.o_ifid_we      = we[STG_IFID];
    assign bus.o_ifid_srst    = srst[STG_IFID];
    assign bus.o_idex_we      = we[STG_IDEX];
    assign bus.o_idex_srst    = srst[STG_IDEX];
    assign bus.o_exmem_we     = we[STG_EXMEM];
    assign bus.o_exmem_srst   = srst[STG_EXMEM];
    assign bus.o_memwb_we     = we[STG_MEMWB];
    assign bus.o_memwb_srst   = srst[STG_MEMWB];
    assign bus.o_mdu_busy     = mdu_busy;
    assign bus.o_stall_cycles = stall_cnt_q;
    assign bus.o_state        = state_q;

endmodule
